// File: rtl/if_id_latch_pkg.sv
// Shared encodings and stage-register field widths for the pipeline latches.
// Reused by the if_id, id_ex and ex_mem stage registers.
package if_id_latch_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;
  localparam int OPC_W   = 5;

  localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 16'h0800;
  localparam logic [OPC_W-1:0]   DEF_HALT_OPC  = 5'b00000;
  localparam int                 DEF_CNT_W     = 16;

  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc2;
  } if_id_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/if_id_latch_if.sv
// Fetch-to-decode bundle: fetch word and stage controls in, latched slot out.
// master = fetch/decode side driving controls, slave = the latch itself.
interface if_id_latch_if #(
  parameter int CNT_W = if_id_latch_pkg::DEF_CNT_W
);
  import if_id_latch_pkg::*;

  logic [INSTR_W-1:0] instr_in;
  logic [PC_W-1:0]    pc_in;
  logic [PC_W-1:0]    pc2_in;
  logic               err_in;
  logic               imem_stall;
  logic               hold;
  logic               flush;

  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    pc_out;
  logic [PC_W-1:0]    pc2_out;
  logic               valid_out;
  logic               err_out;
  logic               halted;
  logic               drop_pending;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output instr_in, pc_in, pc2_in, err_in, imem_stall, hold, flush,
    input  instr_out, pc_out, pc2_out, valid_out, err_out, halted,
           drop_pending, bubble_cnt
  );

  modport slave (
    input  instr_in, pc_in, pc2_in, err_in, imem_stall, hold, flush,
    output instr_out, pc_out, pc2_out, valid_out, err_out, halted,
           drop_pending, bubble_cnt
  );

endinterface

// File: rtl/if_id_latch_sat_counter.sv
// Saturating up-counter: increments on en, sticks at all-ones.
// Latency: one cycle. Backpressure: none, en is sampled every cycle.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (en && cnt != '1)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/reg_16b.sv
// 16-bit register with write enable and async active-high reset to RST_VAL.
// Latency: one cycle. Backpressure: writeEn low holds the stored value.
module reg_16b #(
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        writeEn,
  input  logic [15:0] D,
  output logic [15:0] Q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          Q <= RST_VAL;
    else if (writeEn) Q <= D;
  end

endmodule

// File: rtl/if_id_latch.sv
// IF/ID stage register: fetch word, PC, PC+2 into decode, with bubble/flush/hold.
// Latency: one cycle. Backpressure: hold freezes the slot; imem_stall and flush insert NOPs.
module if_id_latch
  import if_id_latch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR,
  parameter logic [OPC_W-1:0]   HALT_OPC  = DEF_HALT_OPC,
  parameter int                 CNT_W     = DEF_CNT_W
) (
  input logic           clk,
  input logic           rst,
  if_id_latch_if.slave  bus
);

  fetch_state_e state_q, state_d;
  if_id_t       cur, nxt;
  logic         take;
  logic         write_en;
  logic         valid_q;
  logic         err_q;
  logic         halted_q;
  logic         cnt_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // take = a real fetch word is accepted into the slot this cycle
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    if (bus.flush) begin
      state_d = bus.imem_stall ? DROP : RUN;
    end else if (bus.hold) begin
      if (state_q == DROP && !bus.imem_stall) state_d = RUN;
    end else if (!bus.imem_stall) begin
      if (state_q == DROP) state_d = RUN;
      else                 take    = !halted_q;
    end
  end

  assign write_en  = ~bus.hold | bus.flush;
  assign nxt.instr = take ? bus.instr_in : NOP_INSTR;
  assign nxt.pc    = take ? bus.pc_in    : cur.pc;
  assign nxt.pc2   = take ? bus.pc2_in   : cur.pc2;

  reg_16b #(.RST_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .rst(rst), .writeEn(write_en), .D(nxt.instr), .Q(cur.instr)
  );
  reg_16b #(.RST_VAL(16'h0000)) u_pc (
    .clk(clk), .rst(rst), .writeEn(write_en), .D(nxt.pc), .Q(cur.pc)
  );
  reg_16b #(.RST_VAL(16'h0000)) u_pc2 (
    .clk(clk), .rst(rst), .writeEn(write_en), .D(nxt.pc2), .Q(cur.pc2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      if (write_en) valid_q <= take;
      if (take && bus.err_in) err_q <= 1'b1;
      if (take && opcode_of(bus.instr_in) == HALT_OPC) halted_q <= 1'b1;
    end
  end

  // Only fetch-side stalls count; flush and hold cycles are excluded.
  assign cnt_en = bus.imem_stall & ~bus.hold & ~bus.flush;

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .en(cnt_en), .cnt(bus.bubble_cnt)
  );

  assign bus.instr_out    = cur.instr;
  assign bus.pc_out       = cur.pc;
  assign bus.pc2_out      = cur.pc2;
  assign bus.valid_out    = valid_q;
  assign bus.err_out      = err_q;
  assign bus.halted       = halted_q;
  assign bus.drop_pending = (state_q == DROP);

endmodule

// File: tb/tb_if_id_latch.sv
// Directed bench for if_id_latch: a default-width instance plus a 2-bit counter instance.
module tb_if_id_latch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  if_id_latch_if #(.CNT_W(16)) bus ();
  if_id_latch_if #(.CNT_W(2))  bus2 ();

  if_id_latch #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  if_id_latch #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] instr, input logic [15:0] pc, input logic err,
                       input logic stall, input logic hld, input logic fl);
    bus.instr_in   = instr;
    bus.pc_in      = pc;
    bus.pc2_in     = pc + 16'd2;
    bus.err_in     = err;
    bus.imem_stall = stall;
    bus.hold       = hld;
    bus.flush      = fl;
  endtask

  initial begin
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    bus2.instr_in = 16'hC123; bus2.pc_in = 16'h0; bus2.pc2_in = 16'h2;
    bus2.err_in = 1'b0; bus2.imem_stall = 1'b0; bus2.hold = 1'b0; bus2.flush = 1'b0;

    // Reset values
    step(); step();
    chk("rst_instr",  bus.instr_out, 16'h0800);
    chk("rst_valid",  {15'd0, bus.valid_out}, 16'd0);
    chk("rst_pc",     bus.pc_out, 16'h0000);
    chk("rst_bubble", bus.bubble_cnt, 16'd0);
    chk("rst_halted", {15'd0, bus.halted}, 16'd0);
    chk("rst_err",    {15'd0, bus.err_out}, 16'd0);
    rst = 1'b0;

    // Capture
    drive(16'hC123, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("cap_instr", bus.instr_out, 16'hC123);
    chk("cap_pc",    bus.pc_out, 16'h0010);
    chk("cap_pc2",   bus.pc2_out, 16'h0012);
    chk("cap_valid", {15'd0, bus.valid_out}, 16'd1);

    // Hold three cycles with changing inputs; middle one also stalls
    for (int i = 0; i < 3; i++) begin
      drive(16'h1111 + 16'(i), 16'h0020 + 16'(4 * i), 1'b1, (i == 1), 1'b1, 1'b0);
      step();
      chk("hold_instr", bus.instr_out, 16'hC123);
      chk("hold_valid", {15'd0, bus.valid_out}, 16'd1);
    end
    chk("hold_pc",     bus.pc_out, 16'h0010);
    chk("hold_pc2",    bus.pc2_out, 16'h0012);
    chk("hold_err",    {15'd0, bus.err_out}, 16'd0);
    chk("hold_bubble", bus.bubble_cnt, 16'd0);

    // Imem stall bubbles; the narrow instance saturates at 3
    bus2.imem_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(16'h2222, 16'h0030, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      chk("stall_instr", bus.instr_out, 16'h0800);
      chk("stall_valid", {15'd0, bus.valid_out}, 16'd0);
      if (i == 2) chk("sat_mid", {14'd0, bus2.bubble_cnt}, 16'd2);
    end
    chk("stall_bubble", bus.bubble_cnt, 16'd4);
    step();
    chk("sat_top", {14'd0, bus2.bubble_cnt}, 16'd3);
    bus2.imem_stall = 1'b0;

    // Flush during imem stall enters DROP
    drive(16'h3333, 16'h0034, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk("fl_drop",   {15'd0, bus.drop_pending}, 16'd1);
    chk("fl_instr",  bus.instr_out, 16'h0800);
    chk("fl_valid",  {15'd0, bus.valid_out}, 16'd0);
    chk("fl_bubble", bus.bubble_cnt, 16'd5);

    // Returning word is discarded, its error ignored
    drive(16'h4444, 16'h0038, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("drop_instr", bus.instr_out, 16'h0800);
    chk("drop_valid", {15'd0, bus.valid_out}, 16'd0);
    chk("drop_state", {15'd0, bus.drop_pending}, 16'd0);
    chk("drop_err",   {15'd0, bus.err_out}, 16'd0);

    drive(16'h5555, 16'h003A, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("post_instr", bus.instr_out, 16'h5555);
    chk("post_valid", {15'd0, bus.valid_out}, 16'd1);
    chk("post_pc",    bus.pc_out, 16'h003A);

    // DROP consumed while held
    drive(16'h5656, 16'h003C, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    drive(16'h6666, 16'h003E, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("hdrop_state", {15'd0, bus.drop_pending}, 16'd0);
    chk("hdrop_instr", bus.instr_out, 16'h0800);
    chk("hdrop_valid", {15'd0, bus.valid_out}, 16'd0);
    drive(16'h7777, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("hdrop_next", bus.instr_out, 16'h7777);
    chk("hdrop_nval", {15'd0, bus.valid_out}, 16'd1);

    // Flush beats hold; pc kept
    drive(16'h8888, 16'h0044, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("fh_valid", {15'd0, bus.valid_out}, 16'd0);
    chk("fh_instr", bus.instr_out, 16'h0800);
    chk("fh_pc",    bus.pc_out, 16'h0040);

    // HALT with error
    drive(16'h0000, 16'h0050, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("halt_instr",  bus.instr_out, 16'h0000);
    chk("halt_valid",  {15'd0, bus.valid_out}, 16'd1);
    chk("halt_err",    {15'd0, bus.err_out}, 16'd1);
    chk("halt_halted", {15'd0, bus.halted}, 16'd1);
    for (int i = 0; i < 2; i++) begin
      drive(16'hC123, 16'h0052, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("halted_instr", bus.instr_out, 16'h0800);
      chk("halted_valid", {15'd0, bus.valid_out}, 16'd0);
      chk("halted_sticky", {15'd0, bus.halted}, 16'd1);
      chk("err_sticky", {15'd0, bus.err_out}, 16'd1);
    end

    // Enter DROP, then reset mid-cycle
    drive(16'h9999, 16'h0060, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk("pre_rst_drop", {15'd0, bus.drop_pending}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_instr",  bus.instr_out, 16'h0800);
    chk("arst_valid",  {15'd0, bus.valid_out}, 16'd0);
    chk("arst_halted", {15'd0, bus.halted}, 16'd0);
    chk("arst_err",    {15'd0, bus.err_out}, 16'd0);
    chk("arst_bubble", bus.bubble_cnt, 16'd0);
    chk("arst_drop",   {15'd0, bus.drop_pending}, 16'd0);
    chk("arst_sat",    {14'd0, bus2.bubble_cnt}, 16'd0);
    #1 rst = 1'b0;

    drive(16'hC123, 16'h0070, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("rel_instr", bus.instr_out, 16'hC123);
    chk("rel_valid", {15'd0, bus.valid_out}, 16'd1);
    chk("rel_pc2",   bus.pc2_out, 16'h0072);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_latch.md
Name: if_id_latch

Overview:
- Pipeline register between the fetch stage and decode.
- Captures the fetched instruction, its PC and PC+2 each cycle.
- Converts instruction-memory stalls and control redirects into NOP bubbles, and holds its contents on hazard stalls.
- Tracks an in-flight fetch that was squashed by a flush, a sticky HALT condition, and a saturating bubble counter for performance debug.

Parameters:
- NOP_INSTR, 16'h0800, encoding latched for a bubble.
- HALT_OPC, 5'b00000, opcode bits [15:11] that mark HALT.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_in  in  16  instruction word from fetch.
- pc_in  in  16  PC of instr_in.
- pc2_in  in  16  PC+2 of instr_in.
- err_in  in  1  fetch/imem error for instr_in.
- imem_stall  in  1  instruction memory busy; instr_in not valid this cycle.
- hold  in  1  hazard stall from decode; keep the current contents.
- flush  in  1  taken branch/jump redirect; squash the younger instruction.
- instr_out  out  16  latched instruction to decode.
- pc_out  out  16  latched PC.
- pc2_out  out  16  latched PC+2.
- valid_out  out  1  latched slot holds a real instruction.
- err_out  out  1  sticky error, set from a valid captured err_in.
- halted  out  1  sticky: a HALT has been captured.
- drop_pending  out  1  FSM in DROP state (debug).
- bubble_cnt  out  CNT_W  saturating count of imem-stall bubbles.

Behaviour:
- Reset (async, immediate):
  - instr_out=NOP_INSTR; pc_out=0; pc2_out=0; valid_out=0.
  - err_out=0; halted=0; bubble_cnt=0; FSM=RUN.
- FSM states: RUN, DROP. DROP means a fetch is in flight whose returned word must be discarded.
- Per-cycle priority: flush > hold > imem_stall > capture.
- flush=1:
  - Regs <= NOP_INSTR, valid 0; pc/pc2 keep their values.
  - If imem_stall=1, next state is DROP; otherwise RUN.
  - flush overrides hold in the same cycle.
- hold=1 (no flush):
  - All data regs, valid, err_out and bubble_cnt hold.
  - In DROP with imem_stall=0, the returning word is consumed: state -> RUN, regs still held.
- imem_stall=1 (no flush, no hold):
  - Regs <= NOP_INSTR, valid 0.
  - bubble_cnt += 1, saturating at all-ones. State unchanged.
- Capture (all three low):
  - In DROP: regs <= NOP, valid 0, state -> RUN. err_in ignored.
  - In RUN with halted=1: regs <= NOP, valid 0.
  - In RUN with halted=0: instr/pc/pc2 <= inputs, valid 1, err_out |= err_in.
  - On that same valid capture, if instr_in[15:11]==HALT_OPC, set halted (visible next cycle).
- Latency: exactly one cycle from a fetch output to the decode input.
- halted and err_out clear only on rst.
- Reset asserted mid-DROP or mid-hold returns to reset values immediately.
- bubble_cnt does not count flush bubbles or hold cycles.

Decomposition:
- Shared package holds:
  - NOP_INSTR and HALT_OPC.
  - FSM state encoding (RUN=1'b0, DROP=1'b1).
  - Stage-register field widths for reuse by id_ex/ex_mem latches.
- One natural sub-module: sat_counter (width-parameterised saturating incrementer with enable and async reset) for bubble_cnt.
- Data regs are built from the existing reg_16b with writeEn = ~hold | flush, with D muxed to NOP_INSTR where required.

Test Plan:
- Reset: assert rst mid-cycle -> outputs go immediately to instr_out=16'h0800, valid_out=0, bubble_cnt=0, halted=0.
- Capture then hold:
  - Drive instr_in=16'hC123, pc_in=16'h0010, pc2_in=16'h0012 -> next cycle those values appear with valid_out=1.
  - Then hold=1 for 3 cycles with changing inputs -> outputs unchanged.
- Imem stall bubbles: imem_stall=1 for 4 cycles -> instr_out=16'h0800, valid_out=0, bubble_cnt=4. Stall with CNT_W=2 for 5 cycles -> bubble_cnt saturates at 3.
- Flush during imem stall:
  - flush=1 with imem_stall=1 -> drop_pending=1, NOP latched.
  - imem_stall falls with instr_in=16'h4444 -> NOP latched, drop_pending=0.
  - Next instr_in=16'h5555 captured with valid_out=1.
- Flush beats hold: flush=1 and hold=1 together -> valid_out=0, instr_out=16'h0800.
- Halt and error:
  - Capture 16'h0000 with err_in=1 -> valid_out=1, err_out=1, halted=1 next cycle.
  - Subsequent 16'hC123 captures -> NOP, valid_out=0, until rst clears halted.
